// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave receiving 16-bit frames {header[1:0], counter[13:0]} and pulsing accept/reject.
// Optional SPI_RX_ECHO_EN: echo the last accepted frame back on miso; otherwise miso is tied low.
module spi_frame_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [1:0]  HEADER      = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  output logic [13:0] o_counter,
  output logic        o_data_valid,
  output logic        o_frame_err
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;
  logic                   armed_q;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, ss_rise, ss_fall;
  logic start;
  logic frame_ok;

  state_e      state_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] shift_q;
  logic        fall_pend_q;

  // ss resets high and sclk low so reset release never fabricates an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      // Only arm once the chain holds real pin values and ss has been seen high, so a
      // frame interrupted by reset is ignored until its master starts a new one.
      if (flush_q[SYNC_STAGES-1] && ss_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q & armed_q;

  assign start    = (state_q == StIdle) && (ss_fall || fall_pend_q);
  assign frame_ok = (bit_cnt_q == 5'd16) && (shift_q[15:14] == HEADER);

  // The verdict is registered on the SHIFT->CHECK transition so the pulse is visible
  // during the CHECK cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 5'd0;
      shift_q      <= 16'd0;
      fall_pend_q  <= 1'b0;
      o_counter    <= 14'd0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StShift;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 16'd0;
            fall_pend_q <= 1'b0;
          end
        end
        StShift: begin
          if (ss_rise) begin
            state_q <= StCheck;
            if (frame_ok) begin
              o_counter    <= shift_q[13:0];
              o_data_valid <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            shift_q <= {shift_q[14:0], mosi_s};
            if (bit_cnt_q != 5'd17) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
        StCheck: begin
          state_q     <= StIdle;
          fall_pend_q <= ss_fall;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SPI_RX_ECHO_EN
  logic        sclk_fall;
  logic [15:0] echo_q;
  logic [15:0] tx_q;
  logic        miso_q;

  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // tx_q back-fills zeros, so bits past the 16th go out as 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_q <= 16'd0;
      tx_q   <= 16'd0;
      miso_q <= 1'b0;
    end else begin
      if (o_data_valid) begin
        echo_q <= {HEADER, o_counter};
      end
      if (start) begin
        miso_q <= echo_q[15];
        tx_q   <= {echo_q[14:0], 1'b0};
      end else if ((state_q == StShift) && !ss_rise && sclk_fall) begin
        miso_q <= tx_q[15];
        tx_q   <= {tx_q[14:0], 1'b0};
      end else if (state_q != StShift) begin
        miso_q <= 1'b0;
      end
    end
  end

  assign miso = miso_q & ~ss_s;
`else
  assign miso = 1'b0;
`endif

endmodule
